// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a D-mem wait watchdog.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int DMEM_MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_stall,
    input  logic        dmem_stall,
    input  logic        idex_MemRead,
    input  logic [3:0]  idex_RegRd,
    input  logic [3:0]  ifid_RegRs,
    input  logic [3:0]  ifid_RegRt,
    input  logic        branch_taken,
    input  logic        memwb_halt,
    output logic        pc_wen,
    output logic        ifid_wen,
    output logic        idex_wen,
    output logic        exmem_wen,
    output logic        memwb_wen,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    // state | meaning
    // RUN   | normal issue, hazard decode active
    // DWAIT | pipeline frozen waiting on data memory, watchdog counting
    // HALT  | terminal until rst (HLT retired or watchdog expired)
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT = 8'(DMEM_MAX_WAIT);

    state_t     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       halted_q, halted_d;
    logic       mem_err_q, mem_err_d;
    logic       lu;

    assign lu = idex_MemRead && (idex_RegRd != 4'd0) &&
                ((idex_RegRd == ifid_RegRs) || (idex_RegRd == ifid_RegRt));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wcnt_q    <= 8'd0;
            halted_q  <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            halted_q  <= halted_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        halted_d  = halted_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                if (memwb_halt) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else if (dmem_stall) begin
                    state_d = DWAIT;
                    wcnt_d  = 8'd1;
                end
            end
            DWAIT: begin
                if (!dmem_stall) begin
                    state_d = RUN;
                    wcnt_d  = 8'd0;
                end else if (wcnt_q < MAX_WAIT) begin
                    wcnt_d = wcnt_q + 8'd1;
                end else begin
                    state_d   = HALT;
                    mem_err_d = 1'b1;
                    halted_d  = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
                wcnt_d  = 8'd0;
            end
        endcase
    end

    always_comb begin
        pc_wen     = 1'b1;
        ifid_wen   = 1'b1;
        idex_wen   = 1'b1;
        exmem_wen  = 1'b1;
        memwb_wen  = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (memwb_halt || dmem_stall) begin
                        pc_wen    = 1'b0;
                        ifid_wen  = 1'b0;
                        idex_wen  = 1'b0;
                        exmem_wen = 1'b0;
                        memwb_wen = 1'b0;
                    end else if (lu) begin
                        // ID is held, so a branch in ID re-resolves next cycle
                        pc_wen     = 1'b0;
                        ifid_wen   = 1'b0;
                        idex_flush = 1'b1;
                    end else if (branch_taken) begin
                        ifid_flush = 1'b1;
                        pc_wen     = !imem_stall;
                    end else if (imem_stall) begin
                        pc_wen     = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
                DWAIT: begin
                    // The cycle dmem_stall drops the access completes, so the
                    // pipeline is released; hazard decode resumes next cycle.
                    if (dmem_stall) begin
                        pc_wen    = 1'b0;
                        ifid_wen  = 1'b0;
                        idex_wen  = 1'b0;
                        exmem_wen = 1'b0;
                        memwb_wen = 1'b0;
                    end
                end
                default: begin
                    pc_wen    = 1'b0;
                    ifid_wen  = 1'b0;
                    idex_wen  = 1'b0;
                    exmem_wen = 1'b0;
                    memwb_wen = 1'b0;
                end
            endcase
        end
    end

    assign halted  = halted_q;
    assign mem_err = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (state_q != HALT) begin
            if (!pc_wen && (stall_cycles_q != 16'hFFFF))
                stall_cycles_d = stall_cycles_q + 16'd1;
            if ((ifid_flush || idex_flush) && (flush_count_q != 16'hFFFF))
                flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = 16'h0;
    assign flush_count  = 16'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (watchdog limit set to 4).
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_stall, dmem_stall, idex_MemRead, branch_taken, memwb_halt;
    logic [3:0]  idex_RegRd, ifid_RegRs, ifid_RegRt;
    logic        pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic        ifid_flush, idex_flush, halted, mem_err;
    logic [15:0] stall_cycles, flush_count;
    logic [4:0]  wens;
    logic [1:0]  flushes;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    assign wens    = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen};
    assign flushes = {ifid_flush, idex_flush};

    pipe_hazard_ctrl #(.DMEM_MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .idex_MemRead(idex_MemRead), .idex_RegRd(idex_RegRd),
        .ifid_RegRs(ifid_RegRs), .ifid_RegRt(ifid_RegRt),
        .branch_taken(branch_taken), .memwb_halt(memwb_halt),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .idex_wen(idex_wen),
        .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halted(halted), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_in();
        imem_stall = 0; dmem_stall = 0; idex_MemRead = 0; branch_taken = 0;
        memwb_halt = 0; idex_RegRd = 0; ifid_RegRs = 0; ifid_RegRt = 0;
    endtask

    // Check combinational outputs mid-cycle, then advance past the next edge.
    // cnt marks a non-reset, non-HALT cycle for the counter model.
    task automatic cyc(input string tag, input logic [4:0] ew, input logic [1:0] ef, input bit cnt);
        @(negedge clk);
        check({tag, "_wen"}, 32'(wens), 32'(ew));
        check({tag, "_flush"}, 32'(flushes), 32'(ef));
        if (cnt && !ew[4]) exp_stall++;
        if (cnt && ef != 2'b00) exp_flush++;
        @(posedge clk); #1;
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_stall_cnt"}, 32'(stall_cycles), PERF ? 32'(exp_stall) : 32'd0);
        check({tag, "_flush_cnt"}, 32'(flush_count), PERF ? 32'(exp_flush) : 32'd0);
    endtask

    initial begin
        clear_in();
        rst = 1;
        cyc("rst", 5'b11111, 2'b00, 0);
        cyc("rst2", 5'b11111, 2'b00, 0);
        rst = 0;
        check("rst_halted", 32'(halted), 0);
        check("rst_mem_err", 32'(mem_err), 0);
        exp_stall = 0; exp_flush = 0;
        check_cnt("rst");
        cyc("idle", 5'b11111, 2'b00, 1);

        idex_MemRead = 1; idex_RegRd = 3; ifid_RegRs = 3;
        cyc("lu_rs", 5'b00111, 2'b01, 1);
        clear_in();
        cyc("lu_after", 5'b11111, 2'b00, 1);

        idex_MemRead = 1; idex_RegRd = 0; ifid_RegRs = 0; ifid_RegRt = 0;
        cyc("r0_exempt", 5'b11111, 2'b00, 1);

        idex_MemRead = 1; idex_RegRd = 5; ifid_RegRs = 1; ifid_RegRt = 5;
        cyc("lu_rt", 5'b00111, 2'b01, 1);
        branch_taken = 1;
        cyc("br_lu", 5'b00111, 2'b01, 1);
        clear_in();
        branch_taken = 1;
        cyc("br", 5'b11111, 2'b10, 1);
        imem_stall = 1;
        cyc("br_imem", 5'b01111, 2'b10, 1);
        branch_taken = 0;
        cyc("imem", 5'b01111, 2'b10, 1);
        clear_in();
        idex_RegRd = 3; ifid_RegRs = 3;
        cyc("no_load", 5'b11111, 2'b00, 1);
        clear_in();

        // 3-cycle D-mem wait; LU on the first cycle is overridden by the freeze
        dmem_stall = 1; idex_MemRead = 1; idex_RegRd = 2; ifid_RegRs = 2;
        cyc("dw1", 5'b00000, 2'b00, 1);
        clear_in(); dmem_stall = 1;
        cyc("dw2", 5'b00000, 2'b00, 1);
        cyc("dw3", 5'b00000, 2'b00, 1);
        dmem_stall = 0;
        cyc("dw_rel", 5'b11111, 2'b00, 1);
        check("dw_mem_err", 32'(mem_err), 0);
        cyc("dw_idle", 5'b11111, 2'b00, 1);
        check_cnt("mid");

        // Watchdog: limit 4, expires at the end of the 5th stall cycle
        dmem_stall = 1;
        for (int i = 1; i <= 4; i++) cyc($sformatf("wd%0d", i), 5'b00000, 2'b00, 1);
        check("wd4_mem_err", 32'(mem_err), 0);
        check("wd4_halted", 32'(halted), 0);
        cyc("wd5", 5'b00000, 2'b00, 1);
        check("wd_mem_err", 32'(mem_err), 1);
        check("wd_halted", 32'(halted), 1);
        dmem_stall = 0; branch_taken = 1; imem_stall = 1;
        cyc("wd_halt1", 5'b00000, 2'b00, 0);
        clear_in();
        cyc("wd_halt2", 5'b00000, 2'b00, 0);
        check("wd_sticky", 32'(mem_err), 1);
        check_cnt("halt");

        rst = 1; memwb_halt = 1;
        cyc("rst_mid", 5'b11111, 2'b00, 0);
        rst = 0; clear_in();
        exp_stall = 0; exp_flush = 0;
        check("rst2_halted", 32'(halted), 0);
        check("rst2_mem_err", 32'(mem_err), 0);
        check_cnt("rst2");
        cyc("rst2_idle", 5'b11111, 2'b00, 1);

        memwb_halt = 1;
        cyc("hlt", 5'b00000, 2'b00, 1);
        check("hlt_halted", 32'(halted), 1);
        check("hlt_mem_err", 32'(mem_err), 0);
        clear_in();
        cyc("hlt_hold", 5'b00000, 2'b00, 0);
        check_cnt("hlt");
        rst = 1;
        cyc("hlt_rst", 5'b11111, 2'b00, 0);
        rst = 0;
        exp_stall = 0; exp_flush = 0;
        check("hlt_rst_halted", 32'(halted), 0);
        check_cnt("hlt_rst");
        cyc("final", 5'b11111, 2'b00, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
